star_scanner: RTL

//  Parametrised raster scanner for the star-finding pipeline. On start it walks a WIDTH x HEIGHT

---
 rtl/star_scanner_pkg.sv | 25 ++
 rtl/star_scanner_if.sv | 29 ++
 rtl/star_scanner_addr_xlate.sv | 20 ++
 rtl/star_scanner.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/star_scanner_pkg.sv
// Shared definitions for the star scanner: FSM state codes, default geometry
// and the framebuffer address-width helper.
package star_scanner_pkg;

    localparam int DEF_WIDTH  = 6;
    localparam int DEF_HEIGHT = 6;
    localparam int DEF_X_W    = 3;
    localparam int DEF_Y_W    = 3;
    localparam int DEF_COL_W  = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SCAN   = 3'd1;
    localparam logic [2:0] ST_WAIT   = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_REPORT = 3'd4;
    localparam logic [2:0] ST_CLEAR  = 3'd5;
    localparam logic [2:0] ST_NEXT   = 3'd6;
    localparam logic [2:0] ST_DONE   = 3'd7;

    // A 1x1 image still needs a 1-bit address bus.
    function automatic int addr_width(input int width, input int height);
        return (width * height > 1) ? $clog2(width * height) : 1;
    endfunction

endpackage

// File: rtl/star_scanner_if.sv
// Framebuffer port and star-report handshake between the scanner (master)
// and the memory / star mapper side (slave).
interface star_scanner_if
    import star_scanner_pkg::*;
#(
    parameter int ADDR_W = addr_width(DEF_WIDTH, DEF_HEIGHT),
    parameter int COL_W  = DEF_COL_W,
    parameter int X_W    = DEF_X_W,
    parameter int Y_W    = DEF_Y_W
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic [COL_W-1:0]  mem_rdata;
    logic              mem_wren;
    logic [COL_W-1:0]  mem_wdata;
    logic              star_valid;
    logic [X_W-1:0]    star_x;
    logic [Y_W-1:0]    star_y;
    logic              star_ack;

    modport master (
        output mem_addr, mem_wren, mem_wdata, star_valid, star_x, star_y,
        input  mem_rdata, star_ack
    );

    modport slave (
        input  mem_addr, mem_wren, mem_wdata, star_valid, star_x, star_y,
        output mem_rdata, star_ack
    );
endinterface

// File: rtl/star_scanner_addr_xlate.sv
// Combinational {x,y} -> linear framebuffer address for an arbitrary row width.
module scan_addr_xlate
    import star_scanner_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int X_W    = DEF_X_W,
    parameter int Y_W    = DEF_Y_W,
    parameter int ADDR_W = addr_width(DEF_WIDTH, DEF_HEIGHT)
) (
    input  logic [X_W-1:0]    x,
    input  logic [Y_W-1:0]    y,
    output logic [ADDR_W-1:0] addr
);
    localparam logic [ADDR_W-1:0] ROW_LEN = ADDR_W'(WIDTH);

    // x and y are bounded by the image size, so the sum always fits in ADDR_W.
    always_comb begin
        addr = ADDR_W'(y) * ROW_LEN + ADDR_W'(x);
    end
endmodule

// File: rtl/star_scanner.sv
// Raster star scanner: walks the framebuffer row by row, reports each pixel above
// THRESHOLD over a valid/ack handshake, then blanks it once it is acknowledged.
module star_scanner
    import star_scanner_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int HEIGHT    = DEF_HEIGHT,
    parameter int X_W       = DEF_X_W,
    parameter int Y_W       = DEF_Y_W,
    parameter int COL_W     = DEF_COL_W,
    parameter int THRESHOLD = 0,
    parameter int BLANK_COL = 0,
    parameter int RD_LAT    = 1,
    parameter int CNT_W     = 8,
    parameter int ADDR_W    = addr_width(WIDTH, HEIGHT)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    star_scanner_if.master   bus,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] stars_found
);
    localparam logic [X_W-1:0]   X_LAST    = X_W'(WIDTH - 1);
    localparam logic [Y_W-1:0]   Y_LAST    = Y_W'(HEIGHT - 1);
    localparam logic [1:0]       WAIT_LAST = 2'(RD_LAT - 1);
    localparam logic [COL_W-1:0] THRESH    = COL_W'(THRESHOLD);

    logic [2:0]        state_q, state_d;
    logic [X_W-1:0]    x_q, x_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [1:0]        wait_q, wait_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pix_addr;
    logic              wren_q, wren_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    scan_addr_xlate #(
        .WIDTH  (WIDTH),
        .X_W    (X_W),
        .Y_W    (Y_W),
        .ADDR_W (ADDR_W)
    ) u_xlate (
        .x    (x_q),
        .y    (y_q),
        .addr (pix_addr)
    );

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        wait_d  = wait_q;
        addr_d  = addr_q;
        wren_d  = 1'b0;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = done_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SCAN;
                    x_d     = '0;
                    y_d     = '0;
                    cnt_d   = '0;
                    done_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            ST_SCAN: begin
                addr_d  = pix_addr;
                wait_d  = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wait_q == WAIT_LAST) begin
                    state_d = ST_CHECK;
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            ST_CHECK: begin
                if (bus.mem_rdata > THRESH) begin
                    valid_d = 1'b1;
                    state_d = ST_REPORT;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            // The blanking write is armed on the ack edge so it lands in CLEAR only.
            ST_REPORT: begin
                if (bus.star_ack) begin
                    valid_d = 1'b0;
                    wren_d  = 1'b1;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_NEXT;
            end
            ST_NEXT: begin
                if (x_q == X_LAST) begin
                    x_d = '0;
                    if (y_q == Y_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        y_d     = y_q + Y_W'(1);
                        state_d = ST_SCAN;
                    end
                end else begin
                    x_d     = x_q + X_W'(1);
                    state_d = ST_SCAN;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            wait_q  <= '0;
            addr_q  <= '0;
            wren_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            wait_q  <= wait_d;
            addr_q  <= addr_d;
            wren_q  <= wren_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.mem_addr   = addr_q;
    assign bus.mem_wren   = wren_q;
    assign bus.mem_wdata  = COL_W'(BLANK_COL);
    assign bus.star_valid = valid_q;
    assign bus.star_x     = x_q;
    assign bus.star_y     = y_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign stars_found    = cnt_q;
endmodule
